// File: rtl/compressor_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the single compressor input stream.
// A grant is held from the first beat of a packet through its tlast beat.
module compressor_input_arbiter #(
    parameter int N_SRC       = 4,
    parameter int SRC_W       = 2,
    parameter int BURST_WIDTH = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wrt_en,
    input  logic [N_SRC-1:0]             s_tvalid,
    input  logic [N_SRC-1:0]             s_tlast,
    input  logic [N_SRC*BURST_WIDTH-1:0] s_tdata,
    output logic [N_SRC-1:0]             s_tready,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    output logic [BURST_WIDTH-1:0]       m_tdata,
    output logic [SRC_W-1:0]             m_tid,
    input  logic                         m_tready,
    output logic [N_SRC-1:0]             grant,
    output logic [1:0]                   arb_state,
    output logic [15:0]                  pkt_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DRAIN  = 2'b10
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W-1:0] tid_q, tid_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [SRC_W-1:0] winner;
    logic             found;
    logic             xfer_last;
    int               idx;

    // Cyclic search for the first requester at or after rr_q.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = (int'(rr_q) + off) % N_SRC;
            if (!found && s_tvalid[idx]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    // Handshake: a beat moves on any edge where m_tvalid and m_tready are both
    // high; the granted source sees s_tready = m_tready, all others see 0, so
    // everything downstream is gated off by grant_q = 0 in IDLE and in reset.
    always_comb begin
        m_tdata = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                m_tdata = s_tdata[i*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    assign m_tvalid  = |(grant_q & s_tvalid);
    assign m_tlast   = |(grant_q & s_tlast);
    assign s_tready  = grant_q & {N_SRC{m_tready}};
    assign xfer_last = m_tvalid & m_tready & m_tlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        tid_d   = tid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wrt_en && found) begin
                    state_d = STREAM;
                    grant_d = N_SRC'(1) << winner;
                    tid_d   = winner;
                    rr_d    = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + SRC_W'(1);
                end
            end
            STREAM, DRAIN: begin
                // DRAIN only records that wrt_en is low; the packet still runs at full rate.
                if (xfer_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = cnt_q + 16'd1;
                end else if (!wrt_en) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            tid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tid_q   <= tid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign m_tid     = tid_q;
    assign arb_state = state_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_compressor_input_arbiter.sv
// Directed bench for compressor_input_arbiter: arbitration order, pass-through,
// backpressure, drain, asynchronous reset and packet counter wrap.
module tb_compressor_input_arbiter;

    localparam int N  = 4;
    localparam int BW = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            wrt_en;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N*BW-1:0] s_tdata;
    logic [N-1:0]    s_tready;
    logic            m_tvalid;
    logic            m_tlast;
    logic [BW-1:0]   m_tdata;
    logic [1:0]      m_tid;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic [1:0]      arb_state;
    logic [15:0]     pkt_count;

    int n_cmp = 0;
    int n_err = 0;
    int beat_no[N];
    int beats;
    logic [N-1:0]  hs;
    logic [3:0]    exp_q[$];
    logic [15:0]   wrap_exp[3];

    compressor_input_arbiter #(.N_SRC(N), .SRC_W(2), .BURST_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .wrt_en(wrt_en),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tid(m_tid),
        .m_tready(m_tready), .grant(grant), .arb_state(arb_state), .pkt_count(pkt_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // checking and driver tasks
    task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int i, input int b);
        logic [31:0] w;
        w = {8'hA0 + 8'(i), 8'h5C, 16'(b)};
        return {8{w}};
    endfunction

    task automatic set_data();
        for (int i = 0; i < N; i++) s_tdata[i*BW +: BW] = mk(i, beat_no[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wrt_en = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
        for (int i = 0; i < N; i++) beat_no[i] = 1;
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000;
        tick();
        tick();
        check_eq("rst_state", arb_state, 2'b00);
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_cnt", pkt_count, 16'h0000);
        check_eq("rst_tid", m_tid, 2'd0);
        check_eq("rst_ready", s_tready, 4'b0000);
        check_eq("rst_valid", m_tvalid, 1'b0);
        check_eq("rst_data", m_tdata, '0);
        reset = 1'b0;

        // single source, 3-beat packet
        wrt_en = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0001; set_data(); #1;
        check_eq("t1_arb_state", arb_state, 2'b00);
        check_eq("t1_arb_ready", s_tready, 4'b0000);
        check_eq("t1_arb_valid", m_tvalid, 1'b0);
        tick();
        for (int b = 1; b <= 3; b++) begin
            beat_no[0] = b; s_tlast[0] = (b == 3); set_data(); #1;
            check_eq("t1_grant", grant, 4'b0001);
            check_eq("t1_tid", m_tid, 2'd0);
            check_eq("t1_state", arb_state, 2'b01);
            check_eq("t1_data", m_tdata, mk(0, b));
            check_eq("t1_last", m_tlast, (b == 3));
            tick();
        end
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("t1_end_state", arb_state, 2'b00);
        check_eq("t1_end_grant", grant, 4'b0000);
        check_eq("t1_end_cnt", pkt_count, 16'd1);

        // rr_ptr is 1: sources 0 and 1 both request single-beat packets, 1 wins
        beat_no[0] = 1; beat_no[1] = 1; s_tvalid = 4'b0011; s_tlast = 4'b0011; set_data(); #1;
        tick();
        check_eq("rr_grant", grant, 4'b0010);
        check_eq("rr_tid", m_tid, 2'd1);
        check_eq("rr_data", m_tdata, mk(1, 1));
        tick();
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("single_state", arb_state, 2'b00);
        check_eq("single_cnt", pkt_count, 16'd2);

        // all four request 2-beat packets continuously after a fresh reset
        pulse_reset();
        for (int i = 0; i < N; i++) beat_no[i] = 1;
        exp_q = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                  4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        for (int k = 0; k < 15; k++) begin
            s_tvalid = 4'hF;
            for (int i = 0; i < N; i++) s_tlast[i] = (beat_no[i] == 2);
            set_data(); #1;
            check_eq("t2_grant", grant, exp_q.pop_front());
            hs = s_tready & s_tvalid;
            tick();
            for (int i = 0; i < N; i++) if (hs[i]) beat_no[i] = (beat_no[i] == 2) ? 1 : 2;
        end
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("t2_cnt", pkt_count, 16'd5);
        check_eq("t2_state", arb_state, 2'b00);

        // backpressure on a 4-beat packet from source 2
        beats = 0; beat_no[2] = 1; s_tvalid = 4'b0100; set_data(); #1;
        tick();
        s_tvalid = 4'b1111; #1;
        check_eq("t3_grant", grant, 4'b0100);
        check_eq("t3_data1", m_tdata, mk(2, 1));
        if (s_tready[2] && m_tvalid) beats++;
        tick();
        beat_no[2] = 2; set_data(); m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("t3_stall_valid", m_tvalid, 1'b1);
            check_eq("t3_stall_data", m_tdata, mk(2, 2));
            check_eq("t3_stall_ready", s_tready, 4'b0000);
            tick();
        end
        m_tready = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            beat_no[2] = b; s_tlast[2] = (b == 4); set_data(); #1;
            check_eq("t3_data", m_tdata, mk(2, b));
            check_eq("t3_other_ready", s_tready & 4'b1011, 4'b0000);
            if (s_tready[2] && m_tvalid) beats++;
            tick();
        end
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("t3_beats", beats, 4);
        check_eq("t3_cnt", pkt_count, 16'd6);

        // wrt_en drops on beat 2 of 5 from source 1
        beats = 0; beat_no[1] = 1; s_tvalid = 4'b0010; set_data(); #1;
        tick();
        for (int b = 1; b <= 5; b++) begin
            beat_no[1] = b; s_tlast[1] = (b == 5); wrt_en = (b == 1); set_data(); #1;
            if (b >= 3) check_eq("t4_drain", arb_state, 2'b10);
            check_eq("t4_data", m_tdata, mk(1, b));
            if (s_tready[1] && m_tvalid) beats++;
            tick();
        end
        beat_no[1] = 1; s_tlast[1] = 1'b0; set_data(); #1;
        check_eq("t4_beats", beats, 5);
        check_eq("t4_cnt", pkt_count, 16'd7);
        for (int c = 0; c < 2; c++) begin
            check_eq("t4_hold_state", arb_state, 2'b00);
            check_eq("t4_hold_grant", grant, 4'b0000);
            tick();
        end
        wrt_en = 1'b1; #1;
        tick();
        check_eq("t4_regrant", grant, 4'b0010);
        s_tlast[1] = 1'b1; #1;
        tick();
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("t4_cnt2", pkt_count, 16'd8);

        // asynchronous reset between edges in the middle of a packet
        beat_no[3] = 1; s_tvalid = 4'b1000; set_data(); #1;
        tick();
        check_eq("t5_grant", grant, 4'b1000);
        #3 reset = 1'b1;
        #1;
        check_eq("t5_rst_grant", grant, 4'b0000);
        check_eq("t5_rst_ready", s_tready, 4'b0000);
        check_eq("t5_rst_valid", m_tvalid, 1'b0);
        check_eq("t5_rst_state", arb_state, 2'b00);
        check_eq("t5_rst_tid", m_tid, 2'd0);
        check_eq("t5_rst_cnt", pkt_count, 16'd0);
        tick();
        s_tvalid = 4'b1010; reset = 1'b0; beat_no[1] = 1; set_data(); #1;
        tick();
        check_eq("t5_first_grant", grant, 4'b0010);
        check_eq("t5_first_tid", m_tid, 2'd1);
        s_tlast[1] = 1'b1; #1;
        tick();
        s_tvalid = '0; s_tlast = '0; #1;
        check_eq("t5_cnt", pkt_count, 16'd1);

        // counter wrap: preload near the top, then single-beat packets
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        #1;
        check_eq("t6_preload", pkt_count, 16'hFFFD);
        beat_no[0] = 1; s_tvalid = 4'b0001; s_tlast = 4'b0001; set_data(); #1;
        for (int p = 0; p < 3; p++) begin
            tick();
            tick();
            check_eq("t6_wrap_cnt", pkt_count, wrap_exp[p]);
        end
        s_tvalid = '0; s_tlast = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/compressor_input_arbiter.md
Name: compressor_input_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single compressor input stream between N_SRC AXI-stream-style sources (e.g. per-port Ethernet ingress buffers).
- Sits directly upstream of the compressor controller.
- Holds a grant from the first beat of a packet until its tlast beat, so packets are never interleaved.
- Tags each forwarded beat with its source index and counts forwarded packets.

Parameters:
- N_SRC, 4, number of requesting sources; 2..8.
- SRC_W, 2, width of source index; must equal ceil(log2(N_SRC)).
- BURST_WIDTH, 256, data beat width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wrt_en  input  1  global enable; low blocks new grants only.
- s_tvalid  input  N_SRC  per-source beat valid.
- s_tlast  input  N_SRC  per-source last beat of packet.
- s_tdata  input  N_SRC*BURST_WIDTH  per-source beat data; source i occupies [i*BURST_WIDTH +: BURST_WIDTH].
- s_tready  output  N_SRC  per-source ready.
- m_tvalid  output  1  beat valid to compressor.
- m_tlast  output  1  last beat to compressor.
- m_tdata  output  BURST_WIDTH  beat data to compressor.
- m_tid  output  SRC_W  index of granted source.
- m_tready  input  1  compressor ready (compressor controller tready).
- grant  output  N_SRC  one-hot registered grant; all zero when idle.
- arb_state  output  2  00 IDLE, 01 STREAM, 10 DRAIN.
- pkt_count  output  16  packets forwarded since reset; wraps at 0xFFFF->0.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - arb_state=IDLE, grant=0, rr_ptr=0, pkt_count=0, m_tid=0.
  - s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0 (combinational outputs are gated by grant=0).
- A beat transfers on a cycle where the granted source has s_tvalid=1 and m_tready=1.
- IDLE state:
  - If wrt_en=1 and any s_tvalid is set, select the first requester at or after rr_ptr, searching cyclically upward with wrap at N_SRC-1 -> 0.
  - On the next edge: register grant one-hot, set m_tid to the winner, set rr_ptr to (winner+1) mod N_SRC, go to STREAM.
  - All s_tready=0 while in IDLE; no data moves in the arbitration cycle.
  - If wrt_en=0, or no s_tvalid is set, stay in IDLE.
- STREAM state (granted source g):
  - Combinational pass-through: m_tvalid=s_tvalid[g], m_tlast=s_tlast[g], m_tdata=slice g, s_tready[g]=m_tready, all other s_tready=0.
  - Zero added latency on data.
  - On a transfer with s_tlast[g]=1: increment pkt_count, clear grant, go to IDLE.
  - Consequence: back-to-back packets have exactly 1 bubble cycle between them.
  - Requests from non-granted sources are ignored until IDLE; their s_tvalid may stay high indefinitely.
- wrt_en=0 while in STREAM:
  - Go to DRAIN on the next edge.
  - DRAIN behaves exactly like STREAM: the current packet completes at full rate.
  - On its tlast transfer, go to IDLE.
  - If wrt_en returns to 1 before tlast, return to STREAM.
  - Never truncate a packet.
- Stalls:
  - m_tready=0 or s_tvalid[g]=0 simply holds the state; there is no timeout.
- Single-beat packet (tvalid=tlast=1 on the first granted beat): one STREAM cycle, then IDLE.
- Simultaneous requests:
  - Winner is the lowest index >= rr_ptr, then wrapping.
  - A source that has just been served has lowest priority in the next arbitration.
- pkt_count wrap: 0xFFFF + 1 = 0x0000; no saturation.
- Reset mid-packet:
  - The current packet is abandoned: outputs drop the same cycle reset asserts.
  - The upstream source remains responsible for restarting the packet.

Test Plan:
- Reset then single source: s_tvalid=0001, 3-beat packet (tlast on beat 3), m_tready=1 -> IDLE 1 cycle, grant=0001, m_tid=0, 3 beats forwarded with matching m_tdata, arb_state back to 00, pkt_count=1, rr_ptr=1.
- All 4 sources request continuously with 2-beat packets -> grant order 0,1,2,3,0; each packet separated by exactly 1 idle cycle; pkt_count=5 after 15 cycles from the first grant.
- Backpressure: during a granted 4-beat packet from source 2, m_tready low for 3 cycles mid-packet -> m_tdata/m_tvalid held, s_tready[2]=0 during the stall, no other source's s_tready rises, 4 beats total.
- wrt_en drops on beat 2 of 5 -> arb_state=10, packet completes with all 5 beats, then IDLE with no new grant while source 1 requests; wrt_en=1 -> grant=0010 one cycle later.
- Async reset asserted mid-packet (between clock edges) -> grant, s_tready, m_tvalid go to 0 immediately; after release, pkt_count=0 and the first grant goes to the lowest requesting index.
- Counter wrap: force 65536 single-beat packets -> pkt_count returns to 0x0000.
